// File: rtl/lcd_pkg.sv
// Shared constants, types and address helpers for the character-LCD shadow decoder.
package lcd_pkg;

    typedef enum logic {DDRAM, CGRAM} mode_e;
    typedef enum logic [1:0] {FILL, IDLE, WRITE} state_e;

    localparam logic [7:0] FILL_CHAR  = 8'h20;
    localparam logic [6:0] LINE1_BASE = 7'h00;
    localparam logic [6:0] LINE2_BASE = 7'h40;
    localparam logic [6:0] LINE1_END  = 7'h27;
    localparam logic [6:0] LINE2_END  = 7'h67;
    localparam int         VIS_WIDTH  = 16;

    // Command classes, matched as (data & MASK) == MATCH in priority order
    localparam logic [7:0] OP_DDADDR_M = 8'h80, OP_DDADDR_V = 8'h80;
    localparam logic [7:0] OP_CGADDR_M = 8'hC0, OP_CGADDR_V = 8'h40;
    localparam logic [7:0] OP_FUNC_M   = 8'hE0, OP_FUNC_V   = 8'h20;
    localparam logic [7:0] OP_SHIFT_M  = 8'hF0, OP_SHIFT_V  = 8'h10;
    localparam logic [7:0] OP_DISP_M   = 8'hF8, OP_DISP_V   = 8'h08;
    localparam logic [7:0] OP_ENTRY_M  = 8'hFC, OP_ENTRY_V  = 8'h04;
    localparam logic [7:0] OP_HOME_M   = 8'hFE, OP_HOME_V   = 8'h02;
    localparam logic [7:0] OP_CLEAR_M  = 8'hFF, OP_CLEAR_V  = 8'h01;

    function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc);
        if (inc) begin
            if (ac == LINE1_END) return LINE2_BASE;
            if (ac == LINE2_END) return LINE1_BASE;
            return ac + 7'd1;
        end
        if (ac == LINE1_BASE) return LINE2_END;
        if (ac == LINE2_BASE) return LINE1_END;
        return ac - 7'd1;
    endfunction

    // Offsets wrap below each line base, so a single unsigned compare covers the window
    function automatic logic vis_hit(input logic [6:0] ac);
        return ((ac - LINE1_BASE) < 7'(VIS_WIDTH)) || ((ac - LINE2_BASE) < 7'(VIS_WIDTH));
    endfunction

    function automatic logic [4:0] vis_idx(input logic [6:0] ac);
        logic [6:0] off1;
        logic [6:0] off2;
        off1 = ac - LINE1_BASE;
        off2 = ac - LINE2_BASE;
        if (off1 < 7'(VIS_WIDTH)) return {1'b0, off1[3:0]};
        return {1'b1, off2[3:0]};
    endfunction

endpackage

// File: rtl/lcd_shadow_ram.sv
// 32x8 shadow of the visible display; one shared write port, registered read.
module lcd_shadow_ram
    import lcd_pkg::*;
(
    input  logic       clk_i,
    input  logic       fill_we_i,
    input  logic [4:0] fill_addr_i,
    input  logic       dat_we_i,
    input  logic [4:0] dat_addr_i,
    input  logic [7:0] dat_data_i,
    input  logic [4:0] rd_addr_i,
    output logic [7:0] rd_data_o
);
    logic [7:0] mem_q [32];
    logic [7:0] rd_q;
    logic       we;
    logic [4:0] waddr;
    logic [7:0] wdata;

    assign we    = fill_we_i | dat_we_i;
    assign waddr = fill_we_i ? fill_addr_i : dat_addr_i;
    assign wdata = fill_we_i ? FILL_CHAR : dat_data_i;

    always_ff @(posedge clk_i) begin
        if (we) mem_q[waddr] <= wdata;
        rd_q <= mem_q[rd_addr_i];
    end

    assign rd_data_o = rd_q;
endmodule

// File: rtl/lcd_shadow_decoder.sv
// Passive HD44780 bus decoder keeping a shadow of the visible 16x2 window.
module lcd_shadow_decoder
    import lcd_pkg::*;
(
    input  logic       iCLK,
    input  logic       iRST,
    input  logic [7:0] LCD_DATA,
    input  logic       LCD_RS,
    input  logic       LCD_RW,
    input  logic       LCD_EN,
    input  logic [4:0] iRD_ADDR,
    output logic [7:0] oRD_DATA,
    output logic [6:0] oAC,
    output logic       oDISP_ON,
    output logic       oTWO_LINE,
    output logic       oCHAR_VALID,
    output logic [7:0] oCHAR,
    output logic [4:0] oCHAR_POS,
    output logic       oBUSY,
    output logic       oOVERRUN
);
    logic       en_q, rs_q, rw_q, rd_ok_q;
    logic [7:0] data_q;
    state_e     state_q;
    mode_e      mode_q;
    logic       inc_q, disp_q, two_q, cv_q, ovr_q, busy_q;
    logic [6:0] ac_q;
    logic [4:0] fill_cnt_q, pos_q;
    logic [7:0] char_q, ram_rd;
    logic       strobe;

    assign strobe = en_q & ~LCD_EN & ~rw_q;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            en_q <= 1'b0; rs_q <= 1'b0; rw_q <= 1'b0; data_q <= 8'h00;
            rd_ok_q    <= 1'b0;
            state_q    <= FILL;
            fill_cnt_q <= 5'd0;
            busy_q     <= 1'b1;
            mode_q     <= DDRAM;
            inc_q      <= 1'b1;
            ac_q       <= LINE1_BASE;
            disp_q     <= 1'b0;
            two_q      <= 1'b0;
            cv_q       <= 1'b0;
            char_q     <= 8'h00;
            pos_q      <= 5'd0;
            ovr_q      <= 1'b0;
        end else begin
            en_q <= LCD_EN; rs_q <= LCD_RS; rw_q <= LCD_RW; data_q <= LCD_DATA;
            rd_ok_q <= 1'b1;
            cv_q    <= 1'b0;
            ovr_q   <= 1'b0;
            unique case (state_q)
                FILL: begin
                    if (strobe) ovr_q <= 1'b1;
                    fill_cnt_q <= fill_cnt_q + 5'd1;
                    if (fill_cnt_q == 5'd31) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    // WRITE carries the store pulse into the RAM; a new strobe cannot land in it
                    state_q <= IDLE;
                    if (strobe) begin
                        state_q <= WRITE;
                        if (!rs_q) begin
                            if ((data_q & OP_DDADDR_M) == OP_DDADDR_V) begin
                                ac_q <= data_q[6:0]; mode_q <= DDRAM;
                            end else if ((data_q & OP_CGADDR_M) == OP_CGADDR_V) begin
                                mode_q <= CGRAM;
                            end else if ((data_q & OP_FUNC_M) == OP_FUNC_V) begin
                                two_q <= data_q[3];
                            end else if ((data_q & OP_SHIFT_M) == OP_SHIFT_V) begin
                                if (!data_q[3]) ac_q <= ac_step(ac_q, data_q[2]);
                            end else if ((data_q & OP_DISP_M) == OP_DISP_V) begin
                                disp_q <= data_q[2];
                            end else if ((data_q & OP_ENTRY_M) == OP_ENTRY_V) begin
                                inc_q <= data_q[1];
                            end else if ((data_q & OP_HOME_M) == OP_HOME_V) begin
                                ac_q <= LINE1_BASE; mode_q <= DDRAM;
                            end else if ((data_q & OP_CLEAR_M) == OP_CLEAR_V) begin
                                ac_q <= LINE1_BASE; inc_q <= 1'b1; mode_q <= DDRAM;
                                state_q <= FILL; fill_cnt_q <= 5'd0; busy_q <= 1'b1;
                            end
                        end else if (mode_q == DDRAM) begin
                            if (vis_hit(ac_q)) begin
                                cv_q   <= 1'b1;
                                char_q <= data_q;
                                pos_q  <= vis_idx(ac_q);
                            end
                            ac_q <= ac_step(ac_q, inc_q);
                        end
                    end
                end
            endcase
        end
    end

    lcd_shadow_ram u_ram (
        .clk_i       (iCLK),
        .fill_we_i   (state_q == FILL),
        .fill_addr_i (fill_cnt_q),
        .dat_we_i    (cv_q),
        .dat_addr_i  (pos_q),
        .dat_data_i  (char_q),
        .rd_addr_i   (iRD_ADDR),
        .rd_data_o   (ram_rd)
    );

    assign oRD_DATA    = rd_ok_q ? ram_rd : 8'h00;
    assign oAC         = ac_q;
    assign oDISP_ON    = disp_q;
    assign oTWO_LINE   = two_q;
    assign oCHAR_VALID = cv_q;
    assign oCHAR       = char_q;
    assign oCHAR_POS   = pos_q;
    assign oBUSY       = busy_q;
    assign oOVERRUN    = ovr_q;
endmodule

// File: tb/tb_lcd_shadow_decoder.sv
// Directed bench for lcd_shadow_decoder: bus writes, shadow readback and flag checks.
module tb_lcd_shadow_decoder;
    logic       iCLK = 1'b0;
    logic       iRST = 1'b1;
    logic [7:0] LCD_DATA = 8'h00;
    logic       LCD_RS = 1'b0, LCD_RW = 1'b0, LCD_EN = 1'b0;
    logic [4:0] iRD_ADDR = 5'd0;
    logic [7:0] oRD_DATA, oCHAR;
    logic [6:0] oAC;
    logic       oDISP_ON, oTWO_LINE, oCHAR_VALID, oBUSY, oOVERRUN;
    logic [4:0] oCHAR_POS;

    int n_checks = 0;
    int n_err    = 0;
    int busy_cyc = 0;
    int ovr_cnt  = 0;
    logic [4:0] cpos[$];
    logic [7:0] cch[$];

    lcd_shadow_decoder dut (
        .iCLK(iCLK), .iRST(iRST), .LCD_DATA(LCD_DATA), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW),
        .LCD_EN(LCD_EN), .iRD_ADDR(iRD_ADDR), .oRD_DATA(oRD_DATA), .oAC(oAC),
        .oDISP_ON(oDISP_ON), .oTWO_LINE(oTWO_LINE), .oCHAR_VALID(oCHAR_VALID),
        .oCHAR(oCHAR), .oCHAR_POS(oCHAR_POS), .oBUSY(oBUSY), .oOVERRUN(oOVERRUN)
    );

    always #5 iCLK = ~iCLK;

    always @(negedge iCLK) begin
        if (!iRST && oBUSY) busy_cyc++;
        if (!iRST && oOVERRUN) ovr_cnt++;
        if (!iRST && oCHAR_VALID) begin
            cpos.push_back(oCHAR_POS);
            cch.push_back(oCHAR);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One strobe every two cycles: EN high one cycle, low the next
    task automatic lcd_wr(input logic rs, input logic [7:0] d, input logic rw = 1'b0);
        @(posedge iCLK); #1;
        LCD_RS = rs; LCD_RW = rw; LCD_DATA = d; LCD_EN = 1'b1;
        @(posedge iCLK); #1;
        LCD_EN = 1'b0;
    endtask

    task automatic settle();
        repeat (2) @(posedge iCLK);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        @(posedge iCLK); #1;
        while (oBUSY && n < 100) begin
            @(posedge iCLK); #1;
            n++;
        end
        chk(tag, 32'(n < 100), 32'd1);
    endtask

    task automatic rd(input logic [4:0] a, output logic [7:0] d);
        @(posedge iCLK); #1;
        iRD_ADDR = a;
        @(posedge iCLK); #1;
        d = oRD_DATA;
    endtask

    logic [7:0] s1 [10] = '{8'h54, 8'h45, 8'h41, 8'h4D, 8'h20, 8'h41, 8'h20, 8'h57, 8'h49, 8'h4E};
    logic [7:0] s2 [16] = '{8'h43, 8'h4F, 8'h4E, 8'h47, 8'h52, 8'h41, 8'h54, 8'h55,
                            8'h4C, 8'h41, 8'h54, 8'h49, 8'h4F, 8'h4E, 8'h53, 8'h21};

    initial begin
        logic [7:0] d;
        int b0, o0, c0;

        // Reset state
        repeat (3) @(posedge iCLK);
        @(negedge iCLK);
        chk("rst_busy", 32'(oBUSY), 32'd1);
        chk("rst_ac", 32'(oAC), 32'd0);
        chk("rst_rd", 32'(oRD_DATA), 32'd0);
        chk("rst_disp", 32'(oDISP_ON), 32'd0);
        chk("rst_two", 32'(oTWO_LINE), 32'd0);
        chk("rst_cv", 32'(oCHAR_VALID), 32'd0);
        chk("rst_ovr", 32'(oOVERRUN), 32'd0);
        @(posedge iCLK); #1;
        iRST = 1'b0;
        wait_idle("rst_fill_timeout");
        chk("rst_busy_cycles", 32'(busy_cyc), 32'd32);
        for (int i = 0; i < 32; i++) begin
            rd(5'(i), d);
            chk($sformatf("fill_cell%0d", i), 32'(d), 32'h20);
        end
        chk("post_rst_ac", 32'(oAC), 32'd0);
        chk("post_rst_disp", 32'(oDISP_ON), 32'd0);

        // Init sequence and first string
        lcd_wr(0, 8'h38);
        lcd_wr(0, 8'h0C);
        lcd_wr(0, 8'h01);
        wait_idle("init_clear_timeout");
        lcd_wr(0, 8'h06);
        lcd_wr(0, 8'h80);
        settle();
        chk("init_two", 32'(oTWO_LINE), 32'd1);
        chk("init_disp", 32'(oDISP_ON), 32'd1);
        cpos.delete(); cch.delete();
        for (int i = 0; i < 10; i++) lcd_wr(1, s1[i]);
        settle();
        chk("s1_ac", 32'(oAC), 32'h0A);
        chk("s1_pulses", 32'(cpos.size()), 32'd10);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("s1_pos%0d", i), 32'((i < cpos.size()) ? cpos[i] : 5'bx), 32'(i));
            chk($sformatf("s1_chr%0d", i), 32'((i < cch.size()) ? cch[i] : 8'bx), 32'(s1[i]));
            rd(5'(i), d);
            chk($sformatf("s1_cell%0d", i), 32'(d), 32'(s1[i]));
        end

        // Second line, then a byte past the visible window
        lcd_wr(0, 8'hC0);
        for (int i = 0; i < 16; i++) lcd_wr(1, s2[i]);
        settle();
        chk("s2_ac", 32'(oAC), 32'h50);
        for (int i = 0; i < 16; i++) begin
            rd(5'(16 + i), d);
            chk($sformatf("s2_cell%0d", 16 + i), 32'(d), 32'(s2[i]));
        end
        c0 = cpos.size();
        lcd_wr(1, 8'h2E);
        settle();
        chk("s2_17th_ac", 32'(oAC), 32'h51);
        chk("s2_17th_nostore", 32'(cpos.size()), 32'(c0));

        // Line-end wraps in both directions
        lcd_wr(0, 8'hA7);
        lcd_wr(1, 8'h58);
        settle();
        chk("wrap_inc_ac", 32'(oAC), 32'h40);
        chk("wrap_inc_nostore", 32'(cpos.size()), 32'(c0));
        lcd_wr(0, 8'h04);
        lcd_wr(0, 8'h80);
        lcd_wr(1, 8'h59);
        settle();
        chk("wrap_dec_ac", 32'(oAC), 32'h67);
        rd(5'd0, d);
        chk("wrap_dec_cell0", 32'(d), 32'h59);

        // Clear with a strobe landing mid-fill
        b0 = busy_cyc; o0 = ovr_cnt; c0 = cpos.size();
        lcd_wr(0, 8'h01);
        repeat (10) @(posedge iCLK);
        lcd_wr(1, 8'h51);
        wait_idle("ovr_fill_timeout");
        chk("ovr_busy_cycles", 32'(busy_cyc - b0), 32'd32);
        chk("ovr_pulses", 32'(ovr_cnt - o0), 32'd1);
        chk("ovr_nostore", 32'(cpos.size()), 32'(c0));
        chk("ovr_ac", 32'(oAC), 32'd0);
        rd(5'd0, d);
        chk("ovr_cell0", 32'(d), 32'h20);
        rd(5'd16, d);
        chk("ovr_cell16", 32'(d), 32'h20);

        // Read cycles ignored, CGRAM data dropped, DDRAM store resumes
        lcd_wr(0, 8'h85, 1'b1);
        settle();
        chk("rw_ignored_ac", 32'(oAC), 32'd0);
        c0 = cpos.size();
        lcd_wr(0, 8'h40);
        lcd_wr(1, 8'h5A);
        settle();
        chk("cg_ac", 32'(oAC), 32'd0);
        chk("cg_nostore", 32'(cpos.size()), 32'(c0));
        lcd_wr(0, 8'h80);
        lcd_wr(1, 8'h5A);
        settle();
        rd(5'd0, d);
        chk("dd_cell0", 32'(d), 32'h5A);
        chk("dd_ac", 32'(oAC), 32'd1);
        chk("dd_pulses", 32'(cpos.size()), 32'(c0 + 1));

        // Cursor shift, home, display off, function set
        lcd_wr(0, 8'h10);
        lcd_wr(0, 8'h10);
        settle();
        chk("shift_left_wrap", 32'(oAC), 32'h67);
        lcd_wr(0, 8'h14);
        lcd_wr(0, 8'h18);
        settle();
        chk("shift_right_wrap", 32'(oAC), 32'h00);
        lcd_wr(0, 8'h85);
        lcd_wr(0, 8'h02);
        lcd_wr(0, 8'h08);
        lcd_wr(0, 8'h30);
        settle();
        chk("home_ac", 32'(oAC), 32'd0);
        chk("disp_off", 32'(oDISP_ON), 32'd0);
        chk("one_line", 32'(oTWO_LINE), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
